// File: rtl/multi_channel_pooling_layer.sv
// multi_channel_pooling_layer
// Streaming N x N max/average pooling over Channels feature maps processed in
// lock-step. Pixels arrive in raster order with ready/valid on both sides.
// One accumulator per channel per output column is reused for every window row.
// A single output register holds each pooled pixel until the consumer takes it.

module multi_channel_pooling_layer #(
  parameter int BitSize     = 16,
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 8,
  parameter int Channels    = 4,
  parameter int N           = 2,
  parameter int Stride      = 2,
  parameter int Mode        = 0,   // 0 = max, 1 = average
  parameter int Signed      = 1    // 1 = two's complement samples
) (
  input  logic                               clk,
  input  logic                               res,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [Channels-1:0][BitSize-1:0]   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [Channels-1:0][BitSize-1:0]   out_data,
  output logic                               out_last,
  output logic                               frame_done
);

  // Output grid and arithmetic widths.
  localparam int OUT_W  = (ImageWidth  - N) / Stride + 1;
  localparam int OUT_H  = (ImageHeight - N) / Stride + 1;
  localparam int LOG2N  = $clog2(N);
  localparam int SHIFT  = 2 * LOG2N;
  localparam int SUM_W  = BitSize + SHIFT;

  // Counter widths (at least one bit each).
  localparam int COL_W  = (ImageWidth  > 1) ? $clog2(ImageWidth)  : 1;
  localparam int ROW_W  = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
  localparam int OFF_W  = (Stride > 1) ? $clog2(Stride) : 1;
  localparam int CIDX_N = (ImageWidth  - 1) / Stride + 1;
  localparam int RIDX_N = (ImageHeight - 1) / Stride + 1;
  localparam int CIDX_W = (CIDX_N > 1) ? $clog2(CIDX_N) : 1;
  localparam int RIDX_W = (RIDX_N > 1) ? $clog2(RIDX_N) : 1;
  localparam int ACC_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  // Width-matched comparison constants.
  localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(ImageWidth - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(ImageHeight - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST     = OFF_W'(Stride - 1);
  localparam logic [OFF_W-1:0]  WIN_LAST     = OFF_W'(N - 1);
  localparam logic [CIDX_W-1:0] OUT_COL_LAST = CIDX_W'(OUT_W - 1);
  localparam logic [RIDX_W-1:0] OUT_ROW_LAST = RIDX_W'(OUT_H - 1);

  // Raster position: absolute col/row plus position inside the stride (off)
  // and stride-block index (idx), kept as counters to avoid dividers.
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [OFF_W-1:0]  col_off, row_off;
  logic [CIDX_W-1:0] col_idx;
  logic [RIDX_W-1:0] row_idx;

  logic [SUM_W-1:0] acc [OUT_W][Channels];

  logic [SUM_W-1:0] ext_val  [Channels];
  logic [SUM_W-1:0] cur_val  [Channels];
  logic [SUM_W-1:0] comb_val [Channels];
  logic [SUM_W-1:0] avg_val  [Channels];
  logic [Channels-1:0][BitSize-1:0] pooled;

  logic              accept;
  logic              in_window;
  logic              win_first;
  logic              win_last;
  logic              frame_end;
  logic              final_window;
  logic [ACC_AW-1:0] acc_idx;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign in_window    = (row_off <= WIN_LAST) && (col_off <= WIN_LAST) &&
                        (row_idx <= OUT_ROW_LAST) && (col_idx <= OUT_COL_LAST);
  assign win_first    = (row_off == '0) && (col_off == '0);
  assign win_last     = (row_off == WIN_LAST) && (col_off == WIN_LAST);
  assign frame_end    = (col == COL_LAST) && (row == ROW_LAST);
  assign final_window = (row_idx == OUT_ROW_LAST) && (col_idx == OUT_COL_LAST);
  assign acc_idx      = col_idx[ACC_AW-1:0];

  // Per-channel combine of the incoming sample with the running accumulator.
  always_comb begin
    for (int ch = 0; ch < Channels; ch++) begin
      // NOTE: every always_comb output gets a value on every path here, so no
      // latch can be inferred even when the window logic is not active.
      if (Signed != 0) ext_val[ch] = SUM_W'($signed(in_data[ch]));
      else             ext_val[ch] = SUM_W'(in_data[ch]);
      cur_val[ch] = acc[acc_idx][ch];

      if (win_first) begin
        comb_val[ch] = ext_val[ch];
      end else if (Mode == 1) begin
        comb_val[ch] = cur_val[ch] + ext_val[ch];
      end else if (Signed != 0) begin
        comb_val[ch] = ($signed(ext_val[ch]) > $signed(cur_val[ch])) ? ext_val[ch] : cur_val[ch];
      end else begin
        comb_val[ch] = (ext_val[ch] > cur_val[ch]) ? ext_val[ch] : cur_val[ch];
      end

      // Arithmetic shift floors toward -inf for signed sums.
      if (Signed != 0) avg_val[ch] = SUM_W'($signed(comb_val[ch]) >>> SHIFT);
      else             avg_val[ch] = comb_val[ch] >> SHIFT;

      pooled[ch] = (Mode == 1) ? BitSize'(avg_val[ch]) : BitSize'(comb_val[ch]);
    end
  end

  // Raster counters, accumulators, output register and frame-end pulse.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (res) begin
      col        <= '0;
      row        <= '0;
      col_off    <= '0;
      row_off    <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      // NOTE: the accumulator array is only OUT_W x Channels registers, so it
      // is cleared in reset; the first window element overwrites it anyway.
      for (int i = 0; i < OUT_W; i++) begin
        for (int ch = 0; ch < Channels; ch++) begin
          acc[i][ch] <= '0;
        end
      end
    end else begin
      frame_done <= accept && frame_end;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (in_window) begin
          for (int ch = 0; ch < Channels; ch++) begin
            acc[acc_idx][ch] <= comb_val[ch];
          end
          if (win_last) begin
            out_valid <= 1'b1;
            out_data  <= pooled;
            out_last  <= final_window;
          end
        end

        if (col == COL_LAST) begin
          col     <= '0;
          col_off <= '0;
          col_idx <= '0;
          if (row == ROW_LAST) begin
            row     <= '0;
            row_off <= '0;
            row_idx <= '0;
          end else begin
            row <= row + 1'b1;
            if (row_off == OFF_LAST) begin
              row_off <= '0;
              row_idx <= row_idx + 1'b1;
            end else begin
              row_off <= row_off + 1'b1;
            end
          end
        end else begin
          col <= col + 1'b1;
          if (col_off == OFF_LAST) begin
            col_off <= '0;
            col_idx <= col_idx + 1'b1;
          end else begin
            col_off <= col_off + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_pooling_layer.sv
// Directed bench for multi_channel_pooling_layer: three instances (4x4 max,
// 4x4 average, 5x5 max with stride 3) share stimulus; one is selected at a time.

module tb_multi_channel_pooling_layer;

  localparam int BW = 16;
  localparam int CH = 4;
  typedef logic [CH-1:0][BW-1:0] pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  pix_t       in_data = '0;
  logic [1:0] sel = 2'd0;
  logic       done = 1'b0;

  logic [2:0] iv, ir, ov, ol, fd;
  pix_t       od [3];

  assign iv[0] = in_valid && (sel == 2'd0);
  assign iv[1] = in_valid && (sel == 2'd1);
  assign iv[2] = in_valid && (sel == 2'd2);

  multi_channel_pooling_layer #(
    .BitSize(BW), .ImageWidth(4), .ImageHeight(4), .Channels(CH),
    .N(2), .Stride(2), .Mode(0), .Signed(1)
  ) u_max (
    .clk(clk), .res(res), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_last(ol[0]), .frame_done(fd[0])
  );

  multi_channel_pooling_layer #(
    .BitSize(BW), .ImageWidth(4), .ImageHeight(4), .Channels(CH),
    .N(2), .Stride(2), .Mode(1), .Signed(1)
  ) u_avg (
    .clk(clk), .res(res), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_last(ol[1]), .frame_done(fd[1])
  );

  multi_channel_pooling_layer #(
    .BitSize(BW), .ImageWidth(5), .ImageHeight(5), .Channels(CH),
    .N(2), .Stride(3), .Mode(0), .Signed(1)
  ) u_s3 (
    .clk(clk), .res(res), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_last(ol[2]), .frame_done(fd[2])
  );

  // Outputs of the selected instance.
  logic rdy, mov, mlast, mfd;
  pix_t mdata;
  always_comb begin
    rdy   = ir[sel];
    mov   = ov[sel];
    mlast = ol[sel];
    mfd   = fd[sel];
    mdata = od[sel];
  end

  pix_t got_q [$];
  logic last_q [$];
  int   fd_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Record every output handshake and frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mov && out_ready) begin
      got_q.push_back(mdata);
      last_q.push_back(mlast);
    end
    if (mfd) fd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pix_t mk(input int a, input int b, input int c, input int d);
    pix_t v;
    v[0] = 16'(a);
    v[1] = 16'(b);
    v[2] = 16'(c);
    v[3] = 16'(d);
    return v;
  endfunction

  // Channel ramps: p, -p, 100+p, 3p.
  function automatic pix_t pix(input int p);
    return mk(p, -p, 100 + p, 3 * p);
  endfunction

  // Max of a 2x2 window of a 4-wide ramp whose top-left pixel value is b.
  function automatic pix_t exp_max(input int b);
    return mk(b + 5, -b, 105 + b, 3 * (b + 5));
  endfunction

  int base [4] = '{0, 2, 8, 10};

  task automatic do_reset();
    @(posedge clk); #1;
    res = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    res = 1'b0;
    got_q.delete();
    last_q.delete();
    fd_cnt = 0;
  endtask

  // Present one pixel after `gap` idle cycles; returns one step after the accepting edge.
  task automatic drive(input pix_t d, input int gap);
    int tmo;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!rdy && tmo < 200);
    if (!rdy) check("in_ready_timeout", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int off, input int maxgap);
    for (int p = 0; p < w * h; p++) drive(pix(p + off), $urandom_range(0, maxgap));
  endtask

  task automatic wait_out(input int n, input string tag);
    int tmo;
    tmo = 0;
    while (got_q.size() < n && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_frame_max(input string tag, input int first, input int off);
    for (int i = 0; i < 4; i++) begin
      if (first + i < got_q.size()) begin
        check({tag, "_data"}, got_q[first + i], exp_max(base[i] + off));
        check({tag, "_last"}, 64'(last_q[first + i]), 64'(i == 3));
      end
    end
  endtask

  initial begin
    pix_t avg_exp [4];
    pix_t s3_exp [4];
    avg_exp = '{mk(2, -3, 102, 7), mk(4, -5, 104, 13), mk(10, -11, 110, 31), mk(12, -13, 112, 37)};
    s3_exp  = '{mk(6, 0, 106, 18), mk(9, -3, 109, 27), mk(21, -15, 121, 63), mk(24, -18, 124, 72)};

    // Reset state and T1: max pooling, full rate.
    sel = 2'd0;
    out_ready = 1'b1;
    do_reset();
    check("rst_out_valid", 64'(mov), 64'd0);
    check("rst_in_ready", 64'(rdy), 64'd1);
    check("rst_out_data", mdata, '0);
    check("rst_out_last", 64'(mlast), 64'd0);
    check("rst_frame_done", 64'(mfd), 64'd0);
    send_frame(4, 4, 0, 0);
    wait_out(4, "t1");
    check_frame_max("t1", 0, 0);
    check("t1_frame_done", 64'(fd_cnt), 64'd1);

    // T2: average pooling, signed floor on the negative channel.
    sel = 2'd1;
    do_reset();
    send_frame(4, 4, 0, 0);
    wait_out(4, "t2");
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check("t2_data", got_q[i], avg_exp[i]);
        check("t2_last", 64'(last_q[i]), 64'(i == 3));
      end
    end

    // T3: backpressure holds the first result and stalls the input.
    sel = 2'd0;
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) drive(pix(p), 0);
    check("t3_no_early_valid", 64'(mov), 64'd0);
    drive(pix(5), 0);
    check("t3_valid_latency", 64'(mov), 64'd1);
    check("t3_in_ready_low", 64'(rdy), 64'd0);
    check("t3_data", mdata, exp_max(0));
    repeat (3) @(posedge clk);
    #1;
    check("t3_hold_valid", 64'(mov), 64'd1);
    check("t3_hold_data", mdata, exp_max(0));
    check("t3_hold_nopop", 64'(got_q.size()), 64'd0);
    out_ready = 1'b1;
    for (int p = 6; p < 16; p++) drive(pix(p), 0);
    wait_out(4, "t3");
    check_frame_max("t3", 0, 0);

    // T4: 5x5 image, N=2, stride 3; rows/cols 2 are skipped.
    sel = 2'd2;
    do_reset();
    send_frame(5, 5, 0, 0);
    wait_out(4, "t4");
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check("t4_data", got_q[i], s3_exp[i]);
        check("t4_last", 64'(last_q[i]), 64'(i == 3));
      end
    end
    check("t4_frame_done", 64'(fd_cnt), 64'd1);

    // T5: reset mid-frame with a pending output, then a clean frame.
    sel = 2'd0;
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 6; p++) drive(pix(p + 50), 0);
    check("t5_pending", 64'(mov), 64'd1);
    do_reset();
    check("t5_discarded", 64'(mov), 64'd0);
    out_ready = 1'b1;
    send_frame(4, 4, 0, 0);
    wait_out(4, "t5");
    check_frame_max("t5", 0, 0);
    check("t5_frame_done", 64'(fd_cnt), 64'd1);

    // T6: three frames with random input gaps and random out_ready.
    sel = 2'd0;
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(4, 4, 20 * f, 2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_out(12, "t6");
    for (int f = 0; f < 3; f++) check_frame_max("t6", 4 * f, 20 * f);
    check("t6_frame_done", 64'(fd_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
